// File: rtl/acc_dvd_scheduler.sv
// Sequencer for the shared iterative divider: buffers stream bytes, pairs them
// as (dividend, divisor), runs one division at a time and queues quotient/remainder.
module acc_dvd_scheduler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             out_req,
  output logic [WIDTH-1:0] out_data,
  output logic             out_empty,
  output logic             out_full,
  output logic             dvd_start,
  output logic [WIDTH-1:0] dvd_dividend,
  output logic [WIDTH-1:0] dvd_divisor,
  input  logic             dvd_done,
  input  logic [WIDTH-1:0] dvd_quotient,
  input  logic [WIDTH-1:0] dvd_remainder,
  output logic             busy,
  output logic             dz_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_CHECK, S_ISSUE, S_WAIT, S_WR_Q, S_WR_R
  } state_t;

  state_t state, state_nxt;

  // Pointers wrap explicitly so non-power-of-two depths behave as true rings.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [WIDTH-1:0] in_mem [DEPTH];
  logic [AW-1:0]    in_wr, in_rd;
  logic [CW-1:0]    in_cnt;
  logic             in_push, in_pop;

  logic [WIDTH-1:0] out_mem [DEPTH];
  logic [AW-1:0]    out_wr, out_rd;
  logic [CW-1:0]    out_cnt;
  logic             out_push, out_pop, out_room;
  logic [WIDTH-1:0] out_wdata;

  logic [WIDTH-1:0] res_q, res_r;

  assign in_ready  = (in_cnt < CW'(DEPTH));
  assign in_push   = in_valid && in_ready;
  assign out_empty = (out_cnt == '0);
  assign out_full  = (out_cnt == CW'(DEPTH));
  assign out_pop   = out_req && !out_empty;
  assign out_room  = (out_cnt <= CW'(DEPTH - 2));
  assign out_data  = out_empty ? '0 : out_mem[out_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared on reset because the block must come up with
      // all-zero buffers; the loop costs a reset mux per bit, which is accepted here.
      for (int i = 0; i < DEPTH; i++) in_mem[i] <= '0;
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) begin
        in_mem[in_wr] <= in_data;
        in_wr         <= ptr_inc(in_wr);
      end
      if (in_pop) in_rd <= ptr_inc(in_rd);
      in_cnt <= in_cnt + CW'(in_push) - CW'(in_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) out_mem[i] <= '0;
      out_wr  <= '0;
      out_rd  <= '0;
      out_cnt <= '0;
    end else begin
      if (out_push) begin
        out_mem[out_wr] <= out_wdata;
        out_wr          <= ptr_inc(out_wr);
      end
      if (out_pop) out_rd <= ptr_inc(out_rd);
      out_cnt <= out_cnt + CW'(out_push) - CW'(out_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_cnt >= CW'(2)) state_nxt = S_LOAD_A;
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (dvd_divisor == '0) ? S_WR_Q : S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (dvd_done) state_nxt = S_WR_Q;
      S_WR_Q:   if (out_room) state_nxt = S_WR_R;
      S_WR_R:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_pop    = (state == S_LOAD_A) || (state == S_LOAD_B);
    out_push  = ((state == S_WR_Q) && out_room) || (state == S_WR_R);
    out_wdata = (state == S_WR_R) ? res_r : res_q;
    dvd_start = (state == S_ISSUE);
    busy      = (state != S_IDLE);
  end

  // Operands stay put until the next LOAD, so they are stable through WR_Q.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_dividend <= '0;
      dvd_divisor  <= '0;
      res_q        <= '0;
      res_r        <= '0;
      dz_err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      dz_err <= 1'b0;
      case (state)
        S_LOAD_A: dvd_dividend <= in_mem[in_rd];
        S_LOAD_B: dvd_divisor  <= in_mem[in_rd];
        S_CHECK: if (dvd_divisor == '0) begin
          res_q  <= '1;
          res_r  <= dvd_dividend;
          dz_err <= 1'b1;
        end
        S_WAIT: if (dvd_done) begin
          res_q <= dvd_quotient;
          res_r <= dvd_remainder;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_dvd_scheduler.sv
// Scoreboard bench for acc_dvd_scheduler: directed scenarios plus random traffic,
// with outputs checked against a pairing/division model of the byte stream.
module tb_acc_dvd_scheduler;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_req = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_empty, out_full;
  logic             dvd_start;
  logic [WIDTH-1:0] dvd_dividend, dvd_divisor;
  logic             dvd_done = 1'b0;
  logic [WIDTH-1:0] dvd_quotient = '0, dvd_remainder = '0;
  logic             busy, dz_err;

  acc_dvd_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_req(out_req), .out_data(out_data), .out_empty(out_empty), .out_full(out_full),
    .dvd_start(dvd_start), .dvd_dividend(dvd_dividend), .dvd_divisor(dvd_divisor),
    .dvd_done(dvd_done), .dvd_quotient(dvd_quotient), .dvd_remainder(dvd_remainder),
    .busy(busy), .dz_err(dz_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: accepted bytes pair up in order; each pair yields two outputs.
  logic [WIDTH-1:0] in_model[$];
  int exp_out[$];
  int exp_a[$];
  int exp_b[$];
  int starts  = 0;
  int dz_seen = 0;
  int dz_exp  = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_model.delete();
      exp_out.delete();
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (dvd_start) begin
        starts++;
        if (exp_a.size() == 0) check("unexpected dvd_start", 1, 0);
        else begin
          check("dvd_dividend", dvd_dividend, exp_a.pop_front());
          check("dvd_divisor", dvd_divisor, exp_b.pop_front());
        end
      end
      if (dz_err) dz_seen++;
      if (out_req && !out_empty) begin
        if (exp_out.size() == 0) check("unexpected output", out_data, -1);
        else check("out_data", out_data, exp_out.pop_front());
      end
      if (in_valid && in_ready) begin
        in_model.push_back(in_data);
        if (in_model.size() >= 2) begin
          int a, b;
          a = in_model.pop_front();
          b = in_model.pop_front();
          if (b == 0) begin
            exp_out.push_back((1 << WIDTH) - 1);
            exp_out.push_back(a);
            dz_exp++;
          end else begin
            exp_a.push_back(a);
            exp_b.push_back(b);
            exp_out.push_back(a / b);
            exp_out.push_back(a % b);
          end
        end
      end
    end
  end

  // External divider: answers dly cycles after a start pulse, ignores reset.
  int dly  = 8;
  int dcnt = 0;
  logic [WIDTH-1:0] q_hold = '0, r_hold = '0;

  always @(posedge clk) begin
    #1;
    dvd_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        dvd_done      = 1'b1;
        dvd_quotient  = q_hold;
        dvd_remainder = r_hold;
      end
    end
    if (dvd_start) begin
      dcnt   = dly;
      q_hold = (dvd_divisor != 0) ? dvd_dividend / dvd_divisor : '0;
      r_hold = (dvd_divisor != 0) ? dvd_dividend % dvd_divisor : '0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input int b);
    in_valid = 1'b1;
    in_data  = WIDTH'(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_req = 1'b1;
    tick();
    out_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    tick(2);
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({name, " completion"}, int'(busy), 0);
  endtask

  task automatic drain(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 2000) begin
      out_req = !out_empty;
      tick();
      n++;
      if (!busy && out_empty) quiet++;
      else quiet = 0;
    end
    out_req = 1'b0;
    check({name, " drain"}, int'(quiet >= 4), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, n;

    // Reset values
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst in_ready", in_ready, 1);
    check("rst out_empty", out_empty, 1);
    check("rst out_full", out_full, 0);
    check("rst out_data", out_data, 0);
    check("rst dvd_start", dvd_start, 0);
    check("rst dvd_dividend", dvd_dividend, 0);
    check("rst dvd_divisor", dvd_divisor, 0);
    check("rst busy", busy, 0);
    check("rst dz_err", dz_err, 0);
    pop_one();
    check("empty pop out_data", out_data, 0);
    check("empty pop out_empty", out_empty, 1);

    // Normal divide 100/7 with start timing relative to E0
    dly = 8;
    s0 = starts;
    push_byte(100);
    push_byte(7);
    tick(4);
    check("E4 dvd_start", dvd_start, 1);
    check("E4 dividend", dvd_dividend, 100);
    check("E4 divisor", dvd_divisor, 7);
    tick();
    check("E5 dvd_start low", dvd_start, 0);
    wait_done("normal");
    check("normal start count", starts - s0, 1);
    check("normal out_empty", out_empty, 0);
    pop_one();
    pop_one();
    check("normal drained", out_empty, 1);
    check("normal busy", busy, 0);

    // Zero divisor 99/0
    s0 = starts;
    d0 = dz_seen;
    push_byte(99);
    push_byte(0);
    tick(4);
    check("dz E4 dz_err", dz_err, 1);
    check("dz E4 out_empty", out_empty, 1);
    check("dz E4 dvd_start", dvd_start, 0);
    tick();
    check("dz E5 dz_err low", dz_err, 0);
    check("dz E5 out_empty", out_empty, 0);
    check("dz E5 out_data", out_data, 255);
    tick();
    check("dz E6 busy", busy, 0);
    pop_one();
    pop_one();
    check("dz no start", starts - s0, 0);
    check("dz pulse count", dz_seen - d0, 1);

    // Output backpressure
    push_byte(10); push_byte(3); wait_done("bp 1");
    push_byte(50); push_byte(5); wait_done("bp 2");
    check("bp out_full", out_full, 1);
    push_byte(9); push_byte(2);
    tick(20);
    check("bp stalled busy", busy, 1);
    check("bp stalled full", out_full, 1);
    pop_one();
    tick(5);
    check("bp one slot full", out_full, 0);
    check("bp one slot busy", busy, 1);
    pop_one();
    wait_done("bp release");
    check("bp refilled", out_full, 1);
    drain("bp");

    // Input overflow while the FSM is stalled in WR_Q
    push_byte(20); push_byte(6); wait_done("ovf 1");
    push_byte(7);  push_byte(7); wait_done("ovf 2");
    push_byte(9);  push_byte(4);
    tick(20);
    check("ovf stalled", busy, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i + 1);
      check($sformatf("ovf in_ready byte %0d", i + 1), in_ready, (i < DEPTH) ? 1 : 0);
      tick();
    end
    check("ovf full in_ready", in_ready, 0);
    in_data = 8'd6;
    pop_one();
    pop_one();
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("ovf in_ready returns", in_ready, 1);
    drain("ovf");
    push_byte(12); push_byte(3);
    drain("ovf tail");

    // Reset during WAIT, late dvd_done must be ignored
    dly = 30;
    push_byte(40); push_byte(4);
    tick(8);
    check("rwait busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rwait busy cleared", busy, 0);
    check("rwait out_empty", out_empty, 1);
    check("rwait in_ready", in_ready, 1);
    check("rwait dividend", dvd_dividend, 0);
    tick(40);
    check("rwait late done busy", busy, 0);
    check("rwait late done empty", out_empty, 1);
    dly = 8;
    push_byte(8); push_byte(2);
    drain("rwait after");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom_range(0, 255));
      out_req  = $urandom_range(0, 1);
      dly      = $urandom_range(1, 6);
      tick();
    end
    in_valid = 1'b0;
    out_req  = 1'b0;
    drain("random");

    check("outputs outstanding", exp_out.size(), 0);
    check("starts outstanding", exp_a.size(), 0);
    check("dz_err pulse total", dz_seen, dz_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
